// File: rtl/mda_pneumatics_pkg.sv
// Shared types for the pneumatic valve scheduler.
// FSM state encoding and coil select constants.
package mda_pneumatics_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic COIL_EXTEND  = 1'b0;
    localparam logic COIL_RETRACT = 1'b1;

endpackage

// File: rtl/mda_rr_arbiter.sv
// Round-robin channel pick, combinational.
// Search starts at the channel after last_grant and wraps.
module mda_rr_arbiter
    import mda_pneumatics_pkg::*;
#(
    parameter  int NUM_CH = 8,
    localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [GW-1:0]     last_grant,
    output logic [GW-1:0]     winner,
    output logic              valid
);

    int idx;

    // Walk from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(last_grant) + 1 + k) % NUM_CH;
            if (pending[idx]) begin
                winner = GW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mda_pneumatics_scheduler.sv
// Pneumatic valve pulse scheduler: latches fire requests and serves
// them one at a time with a timed coil pulse followed by a dead gap.
module mda_pneumatics_scheduler
    import mda_pneumatics_pkg::*;
#(
    parameter  int NUM_CH       = 8,
    parameter  int PULSE_CYCLES = 5000000,
    parameter  int DEAD_CYCLES  = 2500000,
    localparam int GW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   req,
    input  logic [NUM_CH-1:0]   dir,
    output logic [2*NUM_CH-1:0] pn_out,
    output logic [NUM_CH-1:0]   pending,
    output logic                busy,
    output logic [GW-1:0]       grant_id,
    output logic                done
);

    localparam int MAXC = (PULSE_CYCLES > DEAD_CYCLES) ? PULSE_CYCLES
                                                       : DEAD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_CH-1:0]     dir_q, dir_d;
    logic [NUM_CH-1:0]     pending_d;
    logic [NUM_CH-1:0]     req_m;
    logic [NUM_CH-1:0]     clr;
    logic [2*NUM_CH-1:0]   pn_d;
    logic [GW-1:0]         grant_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  grant_ok;
    logic [GW-1:0]         win;
    logic                  win_valid;

    mda_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .pending    (pending),
        .last_grant (grant_id),
        .winner     (win),
        .valid      (win_valid)
    );

    assign req_m = enable ? req : '0;
    assign dir_d = (dir_q & ~req_m) | (dir & req_m);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pn_d     = '0;
        done_d   = 1'b0;
        grant_d  = grant_id;
        clr      = '0;
        grant_ok = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: grant_ok = win_valid;
                FIRE: begin
                    if (cnt_q == CW'(1)) begin
                        done_d = 1'b1;
                        if (DEAD_CYCLES == 0) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = DEAD;
                            cnt_d   = CW'(DEAD_CYCLES);
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        pn_d  = pn_out;
                    end
                end
                DEAD: begin
                    // Last dead cycle doubles as the idle decision slot.
                    if (cnt_q == CW'(1)) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        grant_ok = win_valid;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (grant_ok) begin
            state_d  = FIRE;
            cnt_d    = CW'(PULSE_CYCLES);
            grant_d  = win;
            clr[win] = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (GW'(i) == win) begin
                    pn_d[2*i+1] = (dir_q[i] == COIL_RETRACT);
                    pn_d[2*i]   = (dir_q[i] == COIL_EXTEND);
                end
            end
        end
        pending_d = enable ? ((pending & ~clr) | req_m) : '0;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dir_q    <= '0;
            pending  <= '0;
            pn_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            grant_id <= GW'(NUM_CH - 1);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            pending  <= pending_d;
            pn_out   <= pn_d;
            busy     <= busy_d;
            done     <= done_d;
            grant_id <= grant_d;
        end
    end

endmodule

// File: tb/tb_mda_pneumatics_scheduler.sv
// Directed bench for the pneumatic scheduler (8 ch, pulse 4, dead 2).
// Each task drives one scenario and checks against hand-derived values.
module tb_mda_pneumatics_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  req;
    logic [7:0]  dir;
    logic [15:0] pn_out;
    logic [7:0]  pending;
    logic        busy;
    logic [2:0]  grant_id;
    logic        done;

    int checks;
    int failures;

    mda_pneumatics_scheduler #(
        .NUM_CH       (8),
        .PULSE_CYCLES (4),
        .DEAD_CYCLES  (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .req      (req),
        .dir      (dir),
        .pn_out   (pn_out),
        .pending  (pending),
        .busy     (busy),
        .grant_id (grant_id),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        dir   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!busy && pending == 8'h00) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_idle_timeout busy=%b pending=%h", tag, busy, pending);
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        apply_reset();
        checks += 5;
        if (pn_out !== 16'h0000) begin
            failures++; $display("FAIL reset_pn got=%h exp=0000", pn_out);
        end
        if (pending !== 8'h00) begin
            failures++; $display("FAIL reset_pending got=%h exp=00", pending);
        end
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        if (done !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%b exp=0", done);
        end
        if (grant_id !== 3'd7) begin
            failures++; $display("FAIL reset_grant got=%0d exp=7", grant_id);
        end
    endtask

    task automatic test_single();
        req = 8'h08; dir = 8'h00;
        tick();
        req = '0;
        checks += 2;
        if (pending !== 8'h08) begin
            failures++; $display("FAIL single_latch got=%h exp=08", pending);
        end
        if (pn_out !== 16'h0000) begin
            failures++; $display("FAIL single_early got=%h exp=0000", pn_out);
        end
        for (int t = 1; t <= 4; t++) begin
            tick();
            checks += 3;
            if (pn_out !== 16'h0040) begin
                failures++; $display("FAIL single_pn t=%0d got=%h exp=0040", t, pn_out);
            end
            if (grant_id !== 3'd3 || pending !== 8'h00) begin
                failures++;
                $display("FAIL single_grant t=%0d got=%0d/%h exp=3/00", t, grant_id, pending);
            end
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL single_busy t=%0d got=%b%b exp=10", t, busy, done);
            end
        end
        tick();
        checks += 2;
        if (pn_out !== 16'h0000) begin
            failures++; $display("FAIL single_off got=%h exp=0000", pn_out);
        end
        if (done !== 1'b1) begin
            failures++; $display("FAIL single_done got=%b exp=1", done);
        end
        tick();
        checks += 2;
        if (done !== 1'b0) begin
            failures++; $display("FAIL single_done_strobe got=%b exp=0", done);
        end
        if (busy !== 1'b1) begin
            failures++; $display("FAIL single_dead_busy got=%b exp=1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL single_busy_end got=%b exp=0", busy);
        end
    endtask

    task automatic test_order();
        logic [15:0] exp_pn;
        logic        exp_done;
        apply_reset();
        req = 8'hA1; dir = 8'h00;
        tick();
        req = '0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            exp_pn   = 16'h0000;
            exp_done = (t == 5 || t == 11 || t == 17);
            if (t >= 1 && t <= 4)   exp_pn = 16'h0001;
            if (t >= 7 && t <= 10)  exp_pn = 16'h0400;
            if (t >= 13 && t <= 16) exp_pn = 16'h4000;
            checks += 2;
            if (pn_out !== exp_pn) begin
                failures++; $display("FAIL order_pn t=%0d got=%h exp=%h", t, pn_out, exp_pn);
            end
            if (done !== exp_done) begin
                failures++; $display("FAIL order_done t=%0d got=%b exp=%b", t, done, exp_done);
            end
        end
        wait_idle("order");
    endtask

    task automatic test_fairness();
        logic [15:0] exp_pn;
        req = 8'h20; dir = 8'h00;
        tick();
        req = '0;
        tick();
        wait_idle("fair_pre");
        checks++;
        if (grant_id !== 3'd5) begin
            failures++; $display("FAIL fair_pre_grant got=%0d exp=5", grant_id);
        end
        req = 8'h44;
        tick();
        req = '0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp_pn = 16'h0000;
            if (t >= 1 && t <= 4)  exp_pn = 16'h1000;
            if (t >= 7 && t <= 10) exp_pn = 16'h0010;
            checks++;
            if (pn_out !== exp_pn) begin
                failures++; $display("FAIL fair_pn t=%0d got=%h exp=%h", t, pn_out, exp_pn);
            end
        end
        wait_idle("fair");
    endtask

    task automatic test_kill();
        req = 8'h18; dir = 8'h00;
        tick();
        req = '0;
        tick();
        checks += 2;
        if (pn_out !== 16'h0040) begin
            failures++; $display("FAIL kill_fire1 got=%h exp=0040", pn_out);
        end
        if (pending !== 8'h10) begin
            failures++; $display("FAIL kill_pend got=%h exp=10", pending);
        end
        tick();
        enable = 1'b0;
        tick();
        checks += 4;
        if (pn_out !== 16'h0000) begin
            failures++; $display("FAIL kill_pn got=%h exp=0000", pn_out);
        end
        if (pending !== 8'h00) begin
            failures++; $display("FAIL kill_pending got=%h exp=00", pending);
        end
        if (done !== 1'b0) begin
            failures++; $display("FAIL kill_done got=%b exp=0", done);
        end
        if (busy !== 1'b0) begin
            failures++; $display("FAIL kill_busy got=%b exp=0", busy);
        end
        req = 8'h04;
        tick();
        req = '0;
        checks++;
        if (pending !== 8'h00) begin
            failures++; $display("FAIL kill_req_ignored got=%h exp=00", pending);
        end
        enable = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            checks++;
            if (pn_out !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL kill_quiet t=%0d got=%h/%b/%b exp=0000/0/0", t, pn_out, done, busy);
            end
        end
    endtask

    task automatic test_collision();
        logic [15:0] exp_pn;
        req = 8'h02; dir = 8'h00;
        tick();
        req = 8'h02; dir = 8'h02;
        tick();
        req = '0; dir = '0;
        checks += 2;
        if (pn_out !== 16'h0004) begin
            failures++; $display("FAIL coll_first got=%h exp=0004", pn_out);
        end
        if (pending !== 8'h02) begin
            failures++; $display("FAIL coll_pend got=%h exp=02", pending);
        end
        for (int t = 2; t <= 12; t++) begin
            tick();
            exp_pn = 16'h0000;
            if (t <= 4)             exp_pn = 16'h0004;
            if (t >= 7 && t <= 10)  exp_pn = 16'h0008;
            checks++;
            if (pn_out !== exp_pn) begin
                failures++; $display("FAIL coll_pn t=%0d got=%h exp=%h", t, pn_out, exp_pn);
            end
        end
        wait_idle("coll");
    endtask

    task automatic test_reset_dead();
        req = 8'h40; dir = 8'h00;
        tick();
        req = '0;
        for (int t = 1; t <= 5; t++) tick();
        checks++;
        if (busy !== 1'b1 || pn_out !== 16'h0000) begin
            failures++; $display("FAIL rdead_pre got=%b/%h exp=1/0000", busy, pn_out);
        end
        reset = 1'b1;
        req   = 8'h04;
        tick();
        reset = 1'b0;
        req   = '0;
        checks += 3;
        if (pn_out !== 16'h0000 || pending !== 8'h00) begin
            failures++; $display("FAIL rdead_clear got=%h/%h exp=0000/00", pn_out, pending);
        end
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL rdead_busy got=%b/%b exp=0/0", busy, done);
        end
        if (grant_id !== 3'd7) begin
            failures++; $display("FAIL rdead_grant got=%0d exp=7", grant_id);
        end
        req = 8'h01;
        tick();
        req = '0;
        tick();
        checks += 2;
        if (pn_out !== 16'h0001) begin
            failures++; $display("FAIL rdead_latency got=%h exp=0001", pn_out);
        end
        if (grant_id !== 3'd0) begin
            failures++; $display("FAIL rdead_grant0 got=%0d exp=0", grant_id);
        end
        wait_idle("rdead");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        req      = '0;
        dir      = '0;
        test_reset();
        test_single();
        test_order();
        test_fairness();
        test_kill();
        test_collision();
        test_reset_dead();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
